// File: rtl/load_return_unit_pkg.sv
// Shared constants and types for the load return path.
// Provides load-type encodings, FSM state encoding, the latched
// request context, and the alignment rule for each load type.
package load_return_unit_pkg;

    localparam int unsigned LRU_AW  = 32;
    localparam int unsigned LRU_DW  = 32;
    localparam int unsigned LRU_OPW = 3;

    // Load type encodings (DEOp)
    localparam logic [LRU_OPW-1:0] DE_LW  = 3'd0;
    localparam logic [LRU_OPW-1:0] DE_LH  = 3'd1;
    localparam logic [LRU_OPW-1:0] DE_LHU = 3'd2;
    localparam logic [LRU_OPW-1:0] DE_LB  = 3'd3;
    localparam logic [LRU_OPW-1:0] DE_LBU = 3'd4;

    typedef enum logic [1:0] {
        LRU_IDLE  = 2'd0,
        LRU_WAIT  = 2'd1,
        LRU_DRAIN = 2'd2,
        LRU_DONE  = 2'd3
    } lru_state_e;

    // Request fields needed later to extract the returned word
    typedef struct packed {
        logic [LRU_OPW-1:0] op;
        logic [1:0]         off;
    } load_ctx_t;

    // Natural alignment check; undefined encodings behave as a word load
    function automatic logic load_aligned(input logic [LRU_OPW-1:0] op,
                                          input logic [1:0]         lo);
        logic ok;
        case (op)
            DE_LH, DE_LHU: ok = ~lo[0];
            DE_LB, DE_LBU: ok = 1'b1;
            DE_LW:         ok = (lo == 2'b00);
            default:       ok = (lo == 2'b00);
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/load_extend.sv
// Combinational byte/halfword select with sign or zero extension.
// Ports:
//   word   - 32-bit word returned by memory
//   offset - byte offset of the load within the word
//   op     - load type (DE_*); undefined types return the word unchanged
//   data   - extended result
module load_extend
    import load_return_unit_pkg::*;
(
    input  logic [LRU_DW-1:0]  word,
    input  logic [1:0]         offset,
    input  logic [LRU_OPW-1:0] op,
    output logic [LRU_DW-1:0]  data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word[{offset, 3'b000} +: 8];
        half_sel = offset[1] ? word[31:16] : word[15:0];
        data     = word;
        case (op)
            DE_LW:  data = word;
            DE_LB:  data = {{24{byte_sel[7]}}, byte_sel};
            DE_LBU: data = {24'd0, byte_sel};
            DE_LH:  data = {{16{half_sel[15]}}, half_sel};
            DE_LHU: data = {16'd0, half_sel};
            default: data = word;
        endcase
    end

endmodule

// File: rtl/load_return_unit.sv
// Load return unit: accepts one load, issues a word-aligned read,
// waits for a variable-latency response, and returns the extended data.
// Flags misaligned/out-of-range loads (AdEL), read timeout (BusErr),
// and drops in-flight loads cancelled by Req.
// Ports:
//   clk, reset            - clock, async active-low reset
//   LoadReq/LoadAddr/DEOp - load request from M stage
//   Req                   - interrupt/exception request, cancels a load
//   Ready                 - unit idle and able to take a request
//   MemRdEn/MemRdAddr     - read strobe and word address to memory
//   MemRdValid/MemRdData  - read response
//   LoadData/LoadValid    - extended result and its valid pulse
//   AdEL, BusErr          - address-error and timeout pulses
module load_return_unit
    import load_return_unit_pkg::*;
#(
    parameter logic [LRU_AW-1:0] ADDR_LO = 32'h0000_0000,
    parameter logic [LRU_AW-1:0] ADDR_HI = 32'h0000_2FFF,
    parameter int unsigned       TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               LoadReq,
    input  logic [LRU_AW-1:0]  LoadAddr,
    input  logic [LRU_OPW-1:0] DEOp,
    input  logic               Req,
    output logic               Ready,
    output logic               MemRdEn,
    output logic [LRU_AW-1:0]  MemRdAddr,
    input  logic               MemRdValid,
    input  logic [LRU_DW-1:0]  MemRdData,
    output logic [LRU_DW-1:0]  LoadData,
    output logic               LoadValid,
    output logic               AdEL,
    output logic               BusErr
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    lru_state_e         state;
    logic [CW-1:0]      cnt;
    load_ctx_t          ctx;
    logic [LRU_DW-1:0]  ext_data;
    logic               in_range;
    logic               req_legal;

    // Offset-based range test avoids a constant compare when ADDR_LO is 0
    assign in_range  = (LoadAddr - ADDR_LO) <= (ADDR_HI - ADDR_LO);
    assign req_legal = in_range && load_aligned(DEOp, LoadAddr[1:0]);

    load_extend u_extend (
        .word   (MemRdData),
        .offset (ctx.off),
        .op     (ctx.op),
        .data   (ext_data)
    );

    // Control FSM with registered outputs; pulses default low each cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= LRU_IDLE;
            Ready     <= 1'b1;
            MemRdEn   <= 1'b0;
            MemRdAddr <= '0;
            LoadData  <= '0;
            LoadValid <= 1'b0;
            AdEL      <= 1'b0;
            BusErr    <= 1'b0;
            cnt       <= '0;
            ctx       <= '0;
        end else begin
            MemRdEn   <= 1'b0;
            LoadValid <= 1'b0;
            AdEL      <= 1'b0;
            BusErr    <= 1'b0;
            case (state)
                LRU_IDLE: begin
                    if (LoadReq && !Req) begin
                        ctx.op  <= DEOp;
                        ctx.off <= LoadAddr[1:0];
                        if (req_legal) begin
                            MemRdEn   <= 1'b1;
                            MemRdAddr <= {LoadAddr[LRU_AW-1:2], 2'b00};
                            cnt       <= '0;
                            Ready     <= 1'b0;
                            state     <= LRU_WAIT;
                        end else begin
                            AdEL <= 1'b1;
                        end
                    end
                end
                LRU_WAIT: begin
                    cnt <= cnt + CW'(1);
                    if (Req) begin
                        // Cancellation wins; a same-cycle response is dropped
                        if (MemRdValid) begin
                            Ready <= 1'b1;
                            state <= LRU_IDLE;
                        end else begin
                            state <= LRU_DRAIN;
                        end
                    end else if (MemRdValid) begin
                        LoadData  <= ext_data;
                        LoadValid <= 1'b1;
                        state     <= LRU_DONE;
                    end else if (cnt == CW'(TIMEOUT - 1)) begin
                        BusErr <= 1'b1;
                        Ready  <= 1'b1;
                        state  <= LRU_IDLE;
                    end
                end
                LRU_DRAIN: begin
                    // Swallow the outstanding response, or give up silently
                    cnt <= cnt + CW'(1);
                    if (MemRdValid || (cnt >= CW'(TIMEOUT - 1))) begin
                        Ready <= 1'b1;
                        state <= LRU_IDLE;
                    end
                end
                LRU_DONE: begin
                    Ready <= 1'b1;
                    state <= LRU_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_return_unit.sv
// Self-checking bench for load_return_unit: directed scenarios followed
// by randomized loads, checked cycle by cycle against an outcome model.
module tb_load_return_unit;
    import load_return_unit_pkg::*;

    localparam int unsigned T         = 16;
    localparam logic [31:0] LAST_ADDR = 32'h0000_2FFF;

    logic        clk;
    logic        reset;
    logic        LoadReq;
    logic [31:0] LoadAddr;
    logic [2:0]  DEOp;
    logic        Req;
    logic        Ready;
    logic        MemRdEn;
    logic [31:0] MemRdAddr;
    logic        MemRdValid;
    logic [31:0] MemRdData;
    logic [31:0] LoadData;
    logic        LoadValid;
    logic        AdEL;
    logic        BusErr;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] last_data = 32'h0;

    load_return_unit dut (
        .clk        (clk),
        .reset      (reset),
        .LoadReq    (LoadReq),
        .LoadAddr   (LoadAddr),
        .DEOp       (DEOp),
        .Req        (Req),
        .Ready      (Ready),
        .MemRdEn    (MemRdEn),
        .MemRdAddr  (MemRdAddr),
        .MemRdValid (MemRdValid),
        .MemRdData  (MemRdData),
        .LoadData   (LoadData),
        .LoadValid  (LoadValid),
        .AdEL       (AdEL),
        .BusErr     (BusErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] flags();
        return {27'd0, Ready, MemRdEn, LoadValid, AdEL, BusErr};
    endfunction

    // Legality: naturally aligned for the type, and within the legal window
    function automatic bit ref_legal(input logic [31:0] a, input logic [2:0] op);
        int unsigned align;
        case (op)
            3'd1, 3'd2: align = 2;
            3'd3, 3'd4: align = 1;
            default:    align = 4;
        endcase
        return (a <= LAST_ADDR) && ((a % align) == 0);
    endfunction

    // Extraction with plain arithmetic: shift, mask, subtract for sign
    function automatic logic [31:0] ref_extract(input logic [31:0] w, input logic [1:0] off,
                                                input logic [2:0] op);
        int unsigned b;
        int unsigned h;
        b = (w >> (8 * int'(off))) & 32'hFF;
        h = (w >> (16 * (int'(off) / 2))) & 32'hFFFF;
        case (op)
            3'd3:    return 32'((b >= 128) ? b - 256 : b);
            3'd4:    return 32'(b);
            3'd1:    return 32'((h >= 32768) ? h - 65536 : h);
            3'd2:    return 32'(h);
            default: return w;
        endcase
    endfunction

    // kind: 0 response in cycle v, 1 no response, 2 Req in cycle r with
    // response in cycle v (0 = never), 3 Req together with LoadReq.
    // Cycle 0 is the request cycle; called at a falling edge.
    task automatic run_load(input logic [31:0] addr, input logic [2:0] op, input int kind,
                            input int v, input int r, input logic [31:0] word);
        bit ign;
        bit lg;
        bit adel;
        int end_c;
        int lv_c;
        int be_c;
        logic [31:0] exp_f;
        ign   = (kind == 3);
        lg    = !ign && ref_legal(addr, op);
        adel  = !ign && !lg;
        lv_c  = 0;
        be_c  = 0;
        end_c = 1;
        if (lg) begin
            case (kind)
                0: begin lv_c = v + 1; end_c = v + 2; end
                1: begin be_c = T + 1; end_c = T + 1; end
                default: begin
                    if (v == r)      end_c = r + 1;
                    else if (v == 0) end_c = T + 1;
                    else             end_c = v + 1;
                end
            endcase
        end
        LoadReq    = 1'b1;
        LoadAddr   = addr;
        DEOp       = op;
        Req        = ign;
        MemRdValid = 1'b0;
        MemRdData  = $urandom;
        for (int c = 1; c <= end_c; c++) begin
            @(negedge clk);
            exp_f = {27'd0, (lg ? (c >= end_c) : 1'b1), (lg && c == 1), (c == lv_c),
                     (adel && c == 1), (c == be_c)};
            chk("flags", flags(), exp_f);
            if (c == lv_c) last_data = ref_extract(word, addr[1:0], op);
            chk("load_data", LoadData, last_data);
            if (lg && c < end_c) chk("rd_addr", MemRdAddr, addr & ~32'h3);
            if (c < end_c) begin
                // Unit is busy: stray requests must be ignored
                LoadReq    = 1'($urandom_range(0, 1));
                LoadAddr   = $urandom;
                DEOp       = 3'($urandom_range(0, 7));
                Req        = (kind == 2) && (c == r);
                MemRdValid = (kind == 0 || kind == 2) && (c == v);
                MemRdData  = (c == v) ? word : $urandom;
            end
        end
        LoadReq    = 1'b0;
        Req        = 1'b0;
        MemRdValid = 1'b0;
    endtask

    initial begin
        logic [31:0] a;
        logic [2:0]  op;
        int          sel;
        int          k;
        int          v;
        int          r;

        reset      = 1'b0;
        LoadReq    = 1'b0;
        LoadAddr   = 32'h0;
        DEOp       = 3'd0;
        Req        = 1'b0;
        MemRdValid = 1'b0;
        MemRdData  = 32'h0;

        @(negedge clk);
        chk("rst_flags", flags(), 32'h10);
        chk("rst_rdaddr", MemRdAddr, 32'h0);
        chk("rst_data", LoadData, 32'h0);
        #2 reset = 1'b1;
        @(negedge clk);

        // Directed scenarios
        run_load(32'h0000_0103, DE_LB, 0, 2, 0, 32'h80FF_1234);
        chk("tp_lb", LoadData, 32'hFFFF_FF80);
        run_load(32'h0000_0202, DE_LHU, 0, 5, 0, 32'h9ABC_5678);
        chk("tp_lhu", LoadData, 32'h0000_9ABC);
        run_load(32'h0000_0202, DE_LH, 0, 5, 0, 32'h9ABC_5678);
        chk("tp_lh", LoadData, 32'hFFFF_9ABC);
        run_load(32'h0000_0101, DE_LW, 0, 1, 0, 32'h0);
        run_load(32'h0000_3000, DE_LB, 0, 1, 0, 32'h0);
        run_load(32'h0000_2FFC, DE_LW, 0, 1, 0, 32'h1357_9BDF);
        chk("tp_lw_top", LoadData, 32'h1357_9BDF);
        run_load(32'h0000_0040, DE_LW, 2, 5, 2, 32'hDEAD_BEEF);
        run_load(32'h0000_0044, DE_LW, 0, 3, 0, 32'hCAFE_F00D);
        chk("tp_after_drain", LoadData, 32'hCAFE_F00D);
        run_load(32'h0000_0048, DE_LW, 1, 0, 0, 32'h0);
        run_load(32'h0000_004C, DE_LW, 2, 3, 3, 32'h1111_2222);
        chk("tp_coincident", LoadData, 32'hCAFE_F00D);
        run_load(32'h0000_0050, 3'd6, 0, 1, 0, 32'h7654_3210);
        chk("tp_undef_op", LoadData, 32'h7654_3210);
        run_load(32'h0000_0054, DE_LW, 3, 0, 0, 32'h0);

        // Randomized loads
        for (int n = 0; n < 300; n++) begin
            op  = 3'($urandom_range(0, 7));
            sel = $urandom_range(0, 9);
            if (sel < 9) begin
                a = $urandom_range(0, 32'h2FFF);
                if (sel < 6) begin
                    if (op == 3'd1 || op == 3'd2)      a = a & ~32'h1;
                    else if (op == 3'd0 || op > 3'd4)  a = a & ~32'h3;
                end
            end else begin
                a = $urandom_range(32'h3000, 32'hFFFF_FFFF);
            end
            k = $urandom_range(0, 9);
            v = 0;
            r = 0;
            if (k <= 5) begin
                k = 0;
                v = $urandom_range(1, T);
            end else if (k == 6) begin
                k = 1;
            end else if (k <= 8) begin
                k = 2;
                r = $urandom_range(1, T - 1);
                case ($urandom_range(0, 2))
                    0:       v = r;
                    1:       v = $urandom_range(r + 1, T);
                    default: v = 0;
                endcase
            end else begin
                k = 3;
            end
            run_load(a, op, k, v, r, $urandom);
        end

        // Asynchronous reset while waiting for a response
        LoadReq  = 1'b1;
        LoadAddr = 32'h0000_0040;
        DEOp     = DE_LW;
        @(negedge clk);
        LoadReq = 1'b0;
        @(negedge clk);
        chk("rst_busy", {31'd0, Ready}, 32'h0);
        #2 reset = 1'b0;
        #1;
        chk("rst_mid_flags", flags(), 32'h10);
        chk("rst_mid_rdaddr", MemRdAddr, 32'h0);
        chk("rst_mid_data", LoadData, 32'h0);
        last_data = 32'h0;
        @(negedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
        MemRdValid = 1'b1;
        MemRdData  = 32'hA5A5_A5A5;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            MemRdValid = 1'b0;
            chk("stray_flags", flags(), 32'h10);
            chk("stray_data", LoadData, 32'h0);
        end
        run_load(32'h0000_0105, DE_LBU, 0, 1, 0, 32'h0000_F000);
        chk("post_rst_lbu", LoadData, 32'h0000_00F0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/load_return_unit.md
Name: load_return_unit

Overview:
- Load-side counterpart of the store byte-enable generator in the P7 memory stage.
- Accepts one load request from the M stage, issues a word-aligned read to data memory/bridge, and waits for a variable-latency response.
- Extracts the addressed byte/halfword with sign or zero extension and returns the result to the W-stage register.
- Detects misaligned and out-of-range loads (AdEL), read timeout, and cancellation by interrupt request (Req).

Parameters:
- ADDR_LO, 32'h0000_0000, lowest legal load address (inclusive).
- ADDR_HI, 32'h0000_2FFF, highest legal load address (inclusive).
- TIMEOUT, 16, cycles in WAIT without MemRdValid before a bus error is raised; must be ≥2.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- LoadReq  in  1  load request; accepted only when Ready=1 and Req=0.
- LoadAddr  in  32  byte address of the load.
- DEOp  in  3  load type: DE_LW, DE_LH, DE_LHU, DE_LB, DE_LBU.
- Req  in  1  interrupt/exception request; cancels an in-flight load.
- Ready  out  1  high in IDLE only.
- MemRdEn  out  1  one-cycle read strobe.
- MemRdAddr  out  32  {LoadAddr[31:2],2'b00}, held stable until the response or drain completes.
- MemRdValid  in  1  read response valid, single-cycle.
- MemRdData  in  32  read response word.
- LoadData  out  32  extended load result.
- LoadValid  out  1  one-cycle pulse; LoadData is valid in this cycle.
- AdEL  out  1  one-cycle address-error pulse.
- BusErr  out  1  one-cycle timeout pulse.

Behaviour:
- Reset (reset=0, asynchronous):
  - State=IDLE, Ready=1, MemRdEn=0, MemRdAddr=0, LoadData=0, LoadValid=0, AdEL=0, BusErr=0, timeout counter=0.
  - Reset is legal mid-operation. Any pending response is forgotten; a later MemRdValid while in IDLE is ignored.
- States: IDLE, WAIT, DRAIN, DONE.
- IDLE + LoadReq & ~Req:
  - Latch the address low bits and DEOp.
  - Check address:
    - DE_LW requires addr[1:0]=0.
    - DE_LH/DE_LHU require addr[0]=0.
    - Address must lie in [ADDR_LO, ADDR_HI].
  - Illegal: no read is issued. AdEL=1 on the next cycle; stay in IDLE with Ready=1 in that cycle.
  - Legal: MemRdEn=1 for exactly the next cycle, MemRdAddr loaded, move to WAIT, Ready=0.
- IDLE + LoadReq & Req: the request is ignored.
- Undefined DEOp: treated as DE_LW.
- WAIT:
  - Timeout counter increments every cycle.
  - MemRdValid & ~Req:
    - Register the extracted data.
    - Move to DONE; LoadValid=1 in the DONE cycle, then IDLE.
    - Minimum latency is 3 cycles from request to LoadValid (response arriving the cycle after MemRdEn).
  - Req=1 without MemRdValid: move to DRAIN.
  - Req and MemRdValid in the same cycle: Req wins. The data is discarded with no LoadValid, and the unit returns to IDLE directly.
  - Counter reaches TIMEOUT: BusErr=1 on the next cycle, return to IDLE, no LoadValid.
- DRAIN:
  - Wait for MemRdValid, discard the data, then go to IDLE.
  - The TIMEOUT counter continues to run. On expiry go to IDLE silently (no BusErr).
  - LoadReq is not accepted while in DRAIN.
- DONE: unconditionally goes to IDLE. A new LoadReq is accepted in the cycle after DONE.
- Extraction (o = latched addr[1:0]):
  - DE_LW: the word as returned.
  - DE_LB/DE_LBU: byte MemRdData[8o+7:8o].
  - DE_LH/DE_LHU: half MemRdData[16o[1]+15:16o[1]].
  - Sign-extend for LB/LH; zero-extend for LBU/LHU.
- At most one of LoadValid, AdEL, BusErr is high in any cycle.
- LoadData holds its last value when LoadValid=0.

Decomposition:
- Shared constants go in head.v:
  - DE_LW=3'd0, DE_LH=3'd1, DE_LHU=3'd2, DE_LB=3'd3, DE_LBU=3'd4.
  - State encodings LRU_IDLE/WAIT/DRAIN/DONE.
- One natural combinational sub-module: load_extend (inputs: word, offset, op; output: extended data). It is reused by any future load path.

Test Plan:
- LB at 0x0000_0103, DEOp=DE_LB, MemRdData=0x80FF_1234 after 1 cycle -> MemRdAddr=0x100, LoadData=0xFFFF_FF80, LoadValid pulses 3 cycles after LoadReq.
- LHU at 0x0000_0202, MemRdData=0x9ABC_5678 after 4 cycles -> LoadData=0x0000_9ABC. LH at the same address -> 0xFFFF_9ABC.
- LW at 0x0000_0101 -> AdEL pulse next cycle, MemRdEn never asserted. LB at 0x0000_3000 -> AdEL (out of range).
- LW issued, Req=1 two cycles into WAIT, MemRdValid arrives 3 cycles later -> no LoadValid; Ready returns the cycle after the response; the next LoadReq completes normally.
- LW issued, MemRdValid never asserted -> BusErr pulses after TIMEOUT=16 cycles, Ready=1 after. Req coincident with MemRdValid -> no LoadValid.
- reset deasserted→asserted low while in WAIT -> all outputs 0 and Ready=1 immediately; a stray MemRdValid after release produces no LoadValid.
